// File: rtl/i2s_stereo_xcvr.sv
// i2s_stereo_xcvr: single-clock I2S slave transceiver. BCLK/LRCK/ADCDAT are
// oversampled in the clk domain. ADC slots are deserialised into {left, right}
// frames, and {left, right} frames are serialised onto DACDAT.
module i2s_stereo_xcvr #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr_status,
    input  logic                  aud_bclk,
    input  logic                  aud_lrck,
    input  logic                  aud_adcdat,
    output logic                  aud_dacdat,
    output logic [2*DATA_W-1:0]   rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [2*DATA_W-1:0]   tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  active
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t                state_q, state_d;
    logic [2:0]            bclk_q, bclk_d;
    logic [1:0]            lrck_q, lrck_d;
    logic [1:0]            adc_q, adc_d;
    logic                  lrck_prev_q, lrck_prev_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0]     rx_word_q, rx_word_d;
    logic [DATA_W-1:0]     rx_left_q, rx_left_d;
    logic [2*DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;
    logic [2*DATA_W-1:0]   tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;
    logic [2*DATA_W-1:0]   tx_frame_q, tx_frame_d;
    logic [DATA_W-1:0]     tx_shift_q, tx_shift_d;
    logic                  dacdat_q, dacdat_d;

    logic                  bclk_rise, bclk_fall, lrck_s, adc_s;
    logic                  bnd, left_bnd, run_act;
    logic                  rx_has_room;
    logic [DATA_W-1:0]     rx_ins, word_done;

    // OR a serial bit into a word at position pos counted from the MSB.
    function automatic logic [DATA_W-1:0] place_bit(input logic [DATA_W-1:0] w,
                                                    input logic b,
                                                    input logic [CNT_W-1:0] pos);
        return w | ({b, {(DATA_W-1){1'b0}}} >> pos);
    endfunction

    assign bclk_rise   = bclk_q[1] & ~bclk_q[2];
    assign bclk_fall   = ~bclk_q[1] & bclk_q[2];
    assign lrck_s      = lrck_q[1];
    assign adc_s       = adc_q[1];
    assign bnd         = bclk_rise && (lrck_s != lrck_prev_q);
    assign left_bnd    = bnd && !lrck_s;
    assign run_act     = (state_q == RUN) && en;
    assign rx_has_room = rx_cnt_q < CNT_W'(DATA_W);
    assign rx_ins      = place_bit(rx_word_q, adc_s, rx_cnt_q);
    assign word_done   = rx_has_room ? rx_ins : rx_word_q;

    // Pin synchronisers; the third BCLK stage feeds the edge detectors.
    always_comb begin
        bclk_d = {bclk_q[1:0], aud_bclk};
        lrck_d = {lrck_q[0], aud_lrck};
        adc_d  = {adc_q[0], aud_adcdat};
    end

    // Framing FSM: wait for a left boundary before running, drop out on en low.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = SYNC;
            SYNC:    if (!en) state_d = IDLE; else if (left_bnd) state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RX capture/publish, TX buffer/shifter and sticky status next-state.
    always_comb begin
        lrck_prev_d = bclk_rise ? lrck_s : lrck_prev_q;
        rx_cnt_d    = rx_cnt_q;
        rx_word_d   = rx_word_q;
        rx_left_d   = rx_left_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        underrun_d  = underrun_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        tx_frame_d  = tx_frame_q;
        tx_shift_d  = tx_shift_q;
        dacdat_d    = dacdat_q;

        // Clear first so that a same-cycle set event wins.
        if (clr_status) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        if (!run_act) begin
            rx_cnt_d   = '0;
            rx_word_d  = '0;
            tx_shift_d = '0;
            dacdat_d   = 1'b0;
        end else begin
            if (bnd) begin
                rx_cnt_d  = '0;
                rx_word_d = '0;
                if (lrck_s) begin
                    rx_left_d  = word_done;
                    tx_shift_d = tx_frame_q[DATA_W-1:0];
                end else begin
                    if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = {rx_left_q, word_done};
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    if (tx_full_q) begin
                        tx_frame_d = tx_buf_q;
                        tx_shift_d = tx_buf_q[2*DATA_W-1:DATA_W];
                        tx_full_d  = 1'b0;
                    end else begin
                        tx_frame_d = '0;
                        tx_shift_d = '0;
                        underrun_d = 1'b1;
                    end
                end
            end else if (bclk_rise && rx_has_room) begin
                rx_word_d = rx_ins;
                rx_cnt_d  = rx_cnt_q + CNT_W'(1);
            end
            if (bclk_fall) begin
                dacdat_d   = tx_shift_q[DATA_W-1];
                tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end
        end

        // The buffer test uses the registered full flag, so a frame offered
        // while the buffer is empty is always taken, even on a boundary.
        if (tx_valid && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end
    end

    // Control state and outputs with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bclk_q      <= '0;
            lrck_q      <= '0;
            adc_q       <= '0;
            lrck_prev_q <= 1'b0;
            rx_cnt_q    <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            tx_full_q   <= 1'b0;
            dacdat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            adc_q       <= adc_d;
            lrck_prev_q <= lrck_prev_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            tx_full_q   <= tx_full_d;
            dacdat_q    <= dacdat_d;
        end
    end

    // Data-only registers; their contents are qualified by the control state.
    always_ff @(posedge clk) begin
        rx_word_q  <= rx_word_d;
        rx_left_q  <= rx_left_d;
        tx_buf_q   <= tx_buf_d;
        tx_frame_q <= tx_frame_d;
        tx_shift_q <= tx_shift_d;
    end

    assign aud_dacdat = dacdat_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_ready   = !tx_full_q;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;
    assign active     = (state_q == RUN);

endmodule

// File: tb/tb_i2s_stereo_xcvr.sv
// Bench for i2s_stereo_xcvr: a codec model drives BCLK = clk/8 with I2S
// framing; expected RX frames and DAC bits are queued and checked by monitors.
module tb_i2s_stereo_xcvr;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n, en, clr_status;
    logic aud_bclk, aud_lrck, aud_adcdat, aud_dacdat;
    logic [2*DW-1:0] rx_data, tx_data;
    logic rx_valid, rx_ready, tx_valid, tx_ready;
    logic overrun, underrun, active;

    int checks = 0;
    int errors = 0;

    logic [2*DW-1:0] rxq[$];
    logic            dacq[$];
    logic            prev_adc = 1'b0;
    logic            pend_vld = 1'b0;
    logic            pend_bit = 1'b0;

    i2s_stereo_xcvr #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_status(clr_status),
        .aud_bclk(aud_bclk), .aud_lrck(aud_lrck), .aud_adcdat(aud_adcdat),
        .aud_dacdat(aud_dacdat), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .overrun(overrun), .underrun(underrun),
        .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic dac_bit(input logic [DW-1:0] w, input int j);
        return (j < DW) ? w[DW-1-j] : 1'b0;
    endfunction

    // One codec slot of s BCLK periods. Data changes on BCLK fall, MSB one
    // period after the LRCK change. Expected DAC bits are queued just before
    // each rise when chk is set; clr_bnd pulses clr_status on the boundary cycle.
    task automatic drive_slot(input logic lr, input logic [31:0] bits, input int s,
                              input logic chk, input logic [DW-1:0] w, input logic clr_bnd);
        for (int k = 0; k < s; k++) begin
            aud_bclk   = 1'b0;
            aud_lrck   = lr;
            aud_adcdat = (k == 0) ? prev_adc : bits[32-k];
            #40;
            if (k == 0) begin
                if (pend_vld) dacq.push_back(pend_bit);
            end else if (chk) begin
                dacq.push_back(dac_bit(w, k-1));
            end
            aud_bclk = 1'b1;
            if (k == 0 && clr_bnd) begin
                #21 clr_status = 1'b1;
                #10 clr_status = 1'b0;
                #9;
            end else begin
                #40;
            end
        end
        prev_adc = bits[32-s];
        pend_vld = chk;
        pend_bit = dac_bit(w, s-1);
    endtask

    task automatic send_tx(input logic [2*DW-1:0] d);
        check("tx_ready_idle", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        #10;
        tx_valid = 1'b0;
        check("tx_ready_full", tx_ready, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dacdat"},   aud_dacdat, 0);
        check({tag, "_rx_data"},  rx_data,    0);
        check({tag, "_rx_valid"}, rx_valid,   0);
        check({tag, "_tx_ready"}, tx_ready,   1);
        check({tag, "_overrun"},  overrun,    0);
        check({tag, "_underrun"}, underrun,   0);
        check({tag, "_active"},   active,     0);
    endtask

    // RX monitor: every completed handshake is compared with the next expected frame.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            if (rxq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected no frame", rx_data);
            end else begin
                check("rx_frame", rx_data, rxq.pop_front());
            end
        end
    end

    // DAC monitor: the codec samples DACDAT on BCLK rise.
    always @(posedge aud_bclk) begin
        if (dacq.size() > 0) check("dacdat_bit", aud_dacdat, dacq.pop_front());
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clr_status = 1'b0;
        aud_bclk = 1'b0; aud_lrck = 1'b0; aud_adcdat = 1'b0;
        rx_ready = 1'b1; tx_valid = 1'b0; tx_data = '0;
        #23;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        en = 1'b1;
        #10;

        // Lock: a right slot, then the first left boundary (no publish).
        drive_slot(1'b1, 32'hFFFF_0000, 16, 1'b0, 16'h0, 1'b0);
        check("active_before_lock", active, 0);
        drive_slot(1'b0, {16'hA5C3, 16'h0}, 16, 1'b0, 16'h0, 1'b0);
        check("active_locked", active, 1);
        check("no_publish_first", rx_valid, 0);
        send_tx(32'h1234_ABCD);
        drive_slot(1'b1, {16'h0F01, 16'h0}, 16, 1'b0, 16'h0, 1'b0);
        rxq.push_back(32'hA5C3_0F01);

        // TX frame moves at this left boundary and plays out MSB-first.
        drive_slot(1'b0, {16'h3C5A, 16'h0}, 16, 1'b1, 16'h1234, 1'b0);
        check("tx_ready_reasserted", tx_ready, 1);
        check("no_underrun_yet", underrun, 0);
        drive_slot(1'b1, {16'h96E1, 16'h0}, 16, 1'b1, 16'hABCD, 1'b0);
        rxq.push_back(32'h3C5A_96E1);

        // Underrun with clr_status on the same cycle: set wins, zeros played.
        drive_slot(1'b0, {16'h5001, 16'h0}, 16, 1'b1, 16'h0000, 1'b1);
        check("underrun_set_wins", underrun, 1);
        check("overrun_clear", overrun, 0);

        // Hold rx_ready low across two publishes.
        rx_ready = 1'b0;
        drive_slot(1'b1, {16'h7E81, 16'h0}, 16, 1'b1, 16'h0000, 1'b0);
        rxq.push_back(32'h5001_7E81);
        drive_slot(1'b0, {16'h1111, 16'h0}, 16, 1'b1, 16'h0000, 1'b0);
        drive_slot(1'b1, {16'h2222, 16'h0}, 16, 1'b1, 16'h0000, 1'b0);
        drive_slot(1'b0, {16'h4444, 16'h0}, 16, 1'b1, 16'h0000, 1'b0);
        check("overrun_set", overrun, 1);
        check("rx_valid_held", rx_valid, 1);
        check("rx_data_retained", rx_data, 32'h5001_7E81);
        rx_ready = 1'b1;
        #10;
        clr_status = 1'b1;
        #10;
        clr_status = 1'b0;
        check("overrun_cleared", overrun, 0);
        check("underrun_cleared", underrun, 0);
        send_tx(32'hC0DE_F00D);
        drive_slot(1'b1, {16'h5555, 16'h0}, 16, 1'b1, 16'h0000, 1'b0);
        rxq.push_back(32'h4444_5555);

        // 32-bit slots: junk after DATA_W bits ignored, DAC zero after DATA_W bits.
        drive_slot(1'b0, {16'h8001, 16'hBEEF}, 32, 1'b1, 16'hC0DE, 1'b0);
        drive_slot(1'b1, {16'h7FFE, 16'hFFFF}, 32, 1'b1, 16'hF00D, 1'b0);
        rxq.push_back(32'h8001_7FFE);
        drive_slot(1'b0, {16'hAAAA, 16'h0}, 16, 1'b1, 16'h0000, 1'b0);

        // en dropped mid-right-slot: no publish until a fresh lock.
        drive_slot(1'b1, {16'h5A5A, 16'h0}, 8, 1'b0, 16'h0, 1'b0);
        en = 1'b0;
        #20;
        check("en_low_active", active, 0);
        check("en_low_dacdat", aud_dacdat, 0);
        en = 1'b1;
        drive_slot(1'b1, 32'h0F0F_0000, 8, 1'b0, 16'h0, 1'b0);
        check("resync_active_wait", active, 0);
        drive_slot(1'b0, {16'h1357, 16'h0}, 16, 1'b0, 16'h0, 1'b0);
        check("relock_active", active, 1);
        check("relock_no_publish", rx_valid, 0);
        drive_slot(1'b1, {16'h2468, 16'h0}, 16, 1'b0, 16'h0, 1'b0);
        rxq.push_back(32'h1357_2468);
        drive_slot(1'b0, {16'hFACE, 16'h0}, 16, 1'b0, 16'h0, 1'b0);

        // Asynchronous reset mid-slot.
        drive_slot(1'b1, {16'hDEAD, 16'h0}, 8, 1'b0, 16'h0, 1'b0);
        rst_n = 1'b0;
        #10;
        check_reset_outputs("midreset");
        #10;
        rst_n = 1'b1;
        drive_slot(1'b1, 32'h3333_0000, 8, 1'b0, 16'h0, 1'b0);
        check("post_reset_active", active, 0);
        drive_slot(1'b0, {16'hCAFE, 16'h0}, 16, 1'b0, 16'h0, 1'b0);
        check("post_reset_no_publish", rx_valid, 0);
        drive_slot(1'b1, {16'hBEAD, 16'h0}, 16, 1'b0, 16'h0, 1'b0);
        rxq.push_back(32'hCAFE_BEAD);
        drive_slot(1'b0, {16'h0000, 16'h0}, 16, 1'b0, 16'h0, 1'b0);
        #200;
        check("rx_queue_drained", rxq.size(), 0);
        check("dac_queue_drained", dacq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
